// File: rtl/rv32i_types.sv
// Shared types for the burst-memory arbiter: FSM state encoding
// and the default line burst length.
package rv32i_types;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ_REQ,
      READ_WAIT
   } bmem_state_t;

   localparam int BMEM_BURST_LEN = 4;
   localparam int BMEM_MAX_PORTS = 8;

   // Index of the lowest set bit; callers pass a one-hot vector.
   function automatic int oh_index(input logic [BMEM_MAX_PORTS-1:0] oh);
      int r;
      r = 0;
      for (int i = BMEM_MAX_PORTS - 1; i >= 0; i--) begin
         if (oh[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant selection for the bmem arbiter; round-robin from ptr,
// or fixed priority (port 0 highest) when BMEM_ARB_FIXED_PRIO_EN is set.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
`ifndef BMEM_ARB_FIXED_PRIO_EN
   input  logic [PW-1:0] ptr,
`endif
   output logic [N-1:0]  gnt
);

`ifdef BMEM_ARB_FIXED_PRIO_EN

   always_comb begin
      gnt = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
         end
      end
   end

`else

   int            k;
   logic [PW-1:0] idx;
   logic          hit;

   // Scan upward from ptr, wrapping, and take the first requester.
   always_comb begin
      gnt = '0;
      k   = 0;
      idx = '0;
      hit = 1'b0;
      for (int i = 0; i < N; i++) begin
         k = int'(ptr) + i;
         if (k >= N) k = k - N;
         idx = PW'(k);
         if (!hit && req[idx]) begin
            gnt[idx] = 1'b1;
            hit      = 1'b1;
         end
      end
   end

`endif

endmodule

// File: rtl/bmem_arbiter.sv
// Multi-port cache-line arbiter onto a single burst memory port.
// Define BMEM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module bmem_arbiter
   import rv32i_types::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int BURST_LEN = BMEM_BURST_LEN
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_PORTS-1:0][31:0] port_addr,
   input  logic [NUM_PORTS-1:0]       port_read,
   input  logic [NUM_PORTS-1:0]       port_write,
   input  logic [NUM_PORTS-1:0][63:0] port_wdata,
   output logic [NUM_PORTS-1:0]       port_wack,
   output logic [63:0]                port_rdata,
   output logic [NUM_PORTS-1:0]       port_rvalid,
   output logic [NUM_PORTS-1:0]       port_done,
   output logic [31:0]                bmem_addr,
   output logic                       bmem_read,
   output logic                       bmem_write,
   output logic [63:0]                bmem_wdata,
   input  logic                       bmem_ready,
   input  logic [31:0]                bmem_raddr,
   input  logic [63:0]                bmem_rdata,
   input  logic                       bmem_rvalid
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
   localparam logic [PW-1:0] TOP  = PW'(NUM_PORTS - 1);

   bmem_state_t          state, state_n;
   logic [PW-1:0]        idx_q, idx_n;
   logic [31:0]          addr_q, addr_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [NUM_PORTS-1:0] req, gnt;
   logic [PW-1:0]        gnt_idx;
   logic                 hit;
   logic                 beat;
   logic                 last;

   assign req     = port_read | port_write;
   assign gnt_idx = PW'(oh_index(BMEM_MAX_PORTS'(gnt)));
   assign hit     = bmem_rvalid && (bmem_raddr == addr_q);

`ifdef BMEM_ARB_FIXED_PRIO_EN

   rr_arbiter #(
      .N   (NUM_PORTS),
      .PW  (PW)
   ) u_arb (
      .req (req),
      .gnt (gnt)
   );

`else

   logic [PW-1:0] ptr, ptr_n;

   rr_arbiter #(
      .N   (NUM_PORTS),
      .PW  (PW)
   ) u_arb (
      .req (req),
      .ptr (ptr),
      .gnt (gnt)
   );

   assign ptr_n = last ? ((idx_q == TOP) ? '0 : idx_q + 1'b1) : ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr <= '0;
      else      ptr <= ptr_n;
   end

`endif

   // A beat is an accepted write or a read beat carrying our address.
   always_comb begin
      beat = 1'b0;
      unique case (state)
         WRITE:     beat = bmem_ready;
         READ_WAIT: beat = hit;
         default:   beat = 1'b0;
      endcase
   end

   assign last = beat && (cnt == LAST);

   always_comb begin
      state_n     = state;
      idx_n       = idx_q;
      addr_n      = addr_q;
      cnt_n       = cnt;
      bmem_addr   = addr_q;
      bmem_read   = 1'b0;
      bmem_write  = 1'b0;
      bmem_wdata  = '0;
      port_wack   = '0;
      port_rvalid = '0;
      port_rdata  = '0;
      port_done   = '0;
      unique case (state)
         IDLE: begin
            if (|req) begin
               idx_n   = gnt_idx;
               addr_n  = port_addr[gnt_idx];
               state_n = port_write[gnt_idx] ? WRITE : READ_REQ;
            end
         end
         WRITE: begin
            bmem_write = 1'b1;
            bmem_wdata = port_wdata[idx_q];
            if (beat) port_wack[idx_q] = 1'b1;
         end
         READ_REQ: begin
            bmem_read = 1'b1;
            if (bmem_ready) state_n = READ_WAIT;
         end
         READ_WAIT: begin
            if (beat) begin
               port_rvalid[idx_q] = 1'b1;
               port_rdata         = bmem_rdata;
            end
         end
         default: state_n = IDLE;
      endcase
      if (beat) cnt_n = cnt + 1'b1;
      if (last) begin
         port_done[idx_q] = 1'b1;
         cnt_n            = '0;
         state_n          = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         idx_q  <= '0;
         addr_q <= '0;
         cnt    <= '0;
      end else begin
         state  <= state_n;
         idx_q  <= idx_n;
         addr_q <= addr_n;
         cnt    <= cnt_n;
      end
   end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Vector-table and scoreboard bench for bmem_arbiter (2 ports, 4-beat bursts).
// Grant-order expectations follow BMEM_ARB_FIXED_PRIO_EN when defined.
module tb_bmem_arbiter;

   localparam logic [31:0] A0  = 32'h0000_1000;
   localparam logic [31:0] A1  = 32'h0000_2000;
   localparam logic [31:0] A1B = 32'h0000_3000;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0][31:0] port_addr;
   logic [1:0]       port_read;
   logic [1:0]       port_write;
   logic [1:0][63:0] port_wdata;
   logic [1:0]       port_wack;
   logic [63:0]      port_rdata;
   logic [1:0]       port_rvalid;
   logic [1:0]       port_done;
   logic [31:0]      bmem_addr;
   logic             bmem_read;
   logic             bmem_write;
   logic [63:0]      bmem_wdata;
   logic             bmem_ready;
   logic [31:0]      bmem_raddr;
   logic [63:0]      bmem_rdata;
   logic             bmem_rvalid;

   always #5 clk = ~clk;

   bmem_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .port_addr   (port_addr),
      .port_read   (port_read),
      .port_write  (port_write),
      .port_wdata  (port_wdata),
      .port_wack   (port_wack),
      .port_rdata  (port_rdata),
      .port_rvalid (port_rvalid),
      .port_done   (port_done),
      .bmem_addr   (bmem_addr),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_ready  (bmem_ready),
      .bmem_raddr  (bmem_raddr),
      .bmem_rdata  (bmem_rdata),
      .bmem_rvalid (bmem_rvalid)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  rd;
      logic [1:0]  wr;
      logic        rdy;
      logic        rv;
      logic [31:0] raddr;
      logic [63:0] rdata;
      logic [31:0] wd;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_addr;
      logic [63:0] e_wd;
      logic [1:0]  e_wack;
      logic [1:0]  e_rvld;
      logic [1:0]  e_done;
   } vec_t;

   typedef struct {
      int          port;
      logic [63:0] data;
   } beat_t;

   int    total = 0;
   int    bad   = 0;
   beat_t sb[$];
   vec_t  tbl[$];

   function automatic vec_t v(
      input logic r, input logic [1:0] rd, input logic [1:0] wr,
      input logic rdy, input logic rv, input logic [31:0] ra,
      input logic [63:0] rdat, input logic [31:0] wd,
      input logic erd, input logic ewr, input logic [31:0] ea,
      input logic [63:0] ewd, input logic [1:0] ewk,
      input logic [1:0] erv, input logic [1:0] edn);
      vec_t x;
      x.rst = r;     x.rd = rd;       x.wr = wr;
      x.rdy = rdy;   x.rv = rv;       x.raddr = ra;
      x.rdata = rdat; x.wd = wd;
      x.e_rd = erd;  x.e_wr = ewr;    x.e_addr = ea;
      x.e_wd = ewd;  x.e_wack = ewk;  x.e_rvld = erv;
      x.e_done = edn;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t x, input string nm);
      beat_t b;
      rst           = x.rst;
      port_read     = x.rd;
      port_write    = x.wr;
      bmem_ready    = x.rdy;
      bmem_rvalid   = x.rv;
      bmem_raddr    = x.raddr;
      bmem_rdata    = x.rdata;
      port_wdata[0] = {32'h0, x.wd};
      port_wdata[1] = {32'h1, x.wd};
      for (int p = 0; p < 2; p++) begin
         if (x.e_rvld[p]) sb.push_back('{p, x.rdata});
      end
      @(negedge clk);
      chk({nm, " bmem_read"}, 64'(bmem_read), 64'(x.e_rd));
      chk({nm, " bmem_write"}, 64'(bmem_write), 64'(x.e_wr));
      chk({nm, " bmem_wdata"}, bmem_wdata, x.e_wd);
      chk({nm, " port_wack"}, 64'(port_wack), 64'(x.e_wack));
      chk({nm, " port_rvalid"}, 64'(port_rvalid), 64'(x.e_rvld));
      chk({nm, " port_done"}, 64'(port_done), 64'(x.e_done));
      if (x.e_rd || x.e_wr)
         chk({nm, " bmem_addr"}, 64'(bmem_addr), 64'(x.e_addr));
      if (port_rvalid != '0) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s sb: unexpected beat %0h on %b", nm,
                     port_rdata, port_rvalid);
         end else begin
            b = sb.pop_front();
            chk({nm, " sb_port"}, 64'(port_rvalid), 64'(2'b01 << b.port));
            chk({nm, " sb_data"}, port_rdata, b.data);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          g;
      logic [31:0] a;
      logic [1:0]  ev;
      logic [31:0] addrs [2];

      rst          = 1'b0;
      port_addr[0] = A0;
      port_addr[1] = A1;
      port_read    = '0;
      port_write   = '0;
      port_wdata   = '0;
      bmem_ready   = 1'b0;
      bmem_raddr   = '0;
      bmem_rdata   = '0;
      bmem_rvalid  = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // port0 read with a stray beat and a gap
      tbl.push_back(v(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 2'b01, 0, 0, 0, 0, 0, 0, 1, 0, A0, 0, 0, 0, 0));
      tbl.push_back(v(1, 2'b01, 0, 1, 0, 0, 0, 0, 1, 0, A0, 0, 0, 0, 0));
      tbl.push_back(v(1, 2'b01, 0, 0, 1, A0, 64'h11, 0, 0, 0, 0, 0, 0, 2'b01, 0));
      tbl.push_back(v(1, 2'b01, 0, 0, 1, 32'hDEAD_0000, 64'h99, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 2'b01, 0, 0, 0, A0, 64'h77, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 2'b01, 0, 0, 1, A0, 64'h22, 0, 0, 0, 0, 0, 0, 2'b01, 0));
      tbl.push_back(v(1, 2'b01, 0, 0, 1, A0, 64'h33, 0, 0, 0, 0, 0, 0, 2'b01, 0));
      tbl.push_back(v(1, 2'b01, 0, 0, 1, A0, 64'h44, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // port1 write with ready toggling
      tbl.push_back(v(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 4; k++) begin
         tbl.push_back(v(1, 0, 2'b10, 0, 0, 0, 0, k, 0, 1, A1,
                         {32'h1, 32'(k)}, 0, 0, 0));
         tbl.push_back(v(1, 0, 2'b10, 1, 0, 0, 0, k, 0, 1, A1,
                         {32'h1, 32'(k)}, 2'b10, 0, (k == 3) ? 2'b10 : 2'b00));
      end
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // port0 read+write together: write wins
      tbl.push_back(v(1, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 4; k++) begin
         tbl.push_back(v(1, 2'b01, 2'b01, 1, 0, 0, 0, 5 + k, 0, 1, A0,
                         {32'h0, 32'(5 + k)}, 2'b01, 0,
                         (k == 3) ? 2'b01 : 2'b00));
      end
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // both ports reading continuously
      port_addr[1] = A1B;
      addrs[0]     = A0;
      addrs[1]     = A1B;
      for (int t = 0; t < 4; t++) begin
`ifdef BMEM_ARB_FIXED_PRIO_EN
         g = 0;
`else
         g = (t % 2 == 0) ? 1 : 0;
`endif
         a  = addrs[g];
         ev = 2'b01 << g;
         apply(v(1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
               $sformatf("alt%0d_idle", t));
         apply(v(1, 2'b11, 0, 1, 0, 0, 0, 0, 1, 0, a, 0, 0, 0, 0),
               $sformatf("alt%0d_req", t));
         for (int k = 0; k < 4; k++) begin
            apply(v(1, 2'b11, 0, 0, 1, a, {32'(t), 32'(k)}, 0, 0, 0, 0, 0,
                    0, ev, (k == 3) ? ev : 2'b00),
                  $sformatf("alt%0d_b%0d", t, k));
         end
      end

      // reset in the middle of a port1 write burst
      apply(v(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_idle");
      apply(v(1, 0, 2'b10, 1, 0, 0, 0, 9, 0, 1, A1B, {32'h1, 32'h9},
              2'b10, 0, 0), "rst_wb1");
      apply(v(1, 0, 2'b10, 1, 0, 0, 0, 10, 0, 1, A1B, {32'h1, 32'ha},
              2'b10, 0, 0), "rst_wb2");
      apply(v(0, 0, 2'b10, 1, 1, A1B, 64'h5, 10, 0, 0, 0, 0, 0, 0, 0),
            "rst_mid");
      apply(v(0, 2'b11, 0, 1, 1, A0, 64'h6, 0, 0, 0, 0, 0, 0, 0, 0),
            "rst_hold");
      apply(v(1, 2'b11, 0, 0, 1, A0, 64'hBAD, 0, 0, 0, 0, 0, 0, 0, 0),
            "post_stale");
      apply(v(1, 2'b11, 0, 0, 0, 0, 0, 0, 1, 0, A0, 0, 0, 0, 0), "post_req0");
      apply(v(1, 2'b11, 0, 1, 0, 0, 0, 0, 1, 0, A0, 0, 0, 0, 0), "post_req1");
      for (int k = 0; k < 4; k++) begin
         apply(v(1, 2'b11, 0, 0, 1, A0, 64'hC0 + 64'(k), 0, 0, 0, 0, 0, 0,
                 2'b01, (k == 3) ? 2'b01 : 2'b00),
               $sformatf("post_b%0d", k));
      end
      apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "end_idle");

      chk("sb_drain", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
